keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, which sets the number of cycles a column is driven before its rows are sampled; legal range is 3 or more.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, which sets the number of consecutive disagreeing samples needed to change a key state; legal range is 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port col_out, output, 4 bits: active-low column drive, with exactly one bit low at any time.
REQ-006 SHALL have port row_in, input, 4 bits: asynchronous, active-low row sense; 0 means pressed.
REQ-007 SHALL have port event_valid, output, 1 bit: a key event is pending.
REQ-008 SHALL have port event_ready, input, 1 bit: the consumer accepts the event.
REQ-009 SHALL have port event_key, output, 4 bits: key index = row*4 + col.
REQ-010 SHALL have port event_pressed, output, 1 bit: 1 for press, 0 for release.
REQ-011 SHALL have port keys_state, output, 16 bits: debounced pressed map, where bit k is key k.

Function
REQ-012 SHALL pass row_in through a 2-flop synchronizer before any use.
REQ-013 SHALL implement the states SETTLE, CHECK and EMIT.
REQ-014 SETTLE SHALL load its counter with SETTLE_CYCLES-1 on entry and decrement it each cycle.
REQ-015 At SETTLE count 0, the block SHALL latch sample = ~synced_rows, set row index to 0 and go to CHECK.
REQ-016 CHECK SHALL process one row per cycle, for key k = row*4 + col.
REQ-017 In CHECK, if sample[row] == keys_state[k], the block SHALL clear cnt[k] to 0 and advance.
REQ-018 In CHECK, if sample[row] != keys_state[k] and cnt[k] < DEBOUNCE_SCANS-1, the block SHALL increment cnt[k] and advance.
REQ-019 In CHECK, if sample[row] != keys_state[k] and cnt[k] == DEBOUNCE_SCANS-1, the block SHALL:
- clear cnt[k];
- toggle keys_state[k];
- register event_key = k and event_pressed = sample[row];
- set event_valid = 1 and go to EMIT.
REQ-020 Advance SHALL behave as follows:
- If row < 3, the block increments row and stays in CHECK.
- Otherwise it moves the column (3 wraps to 0), updates col_out in the same edge, and enters SETTLE.
REQ-021 EMIT SHALL hold event_valid, event_key, event_pressed, col_out, row, col and all counters stable while event_ready = 0.
REQ-022 In EMIT with event_ready = 1, the block SHALL clear event_valid on that edge and perform advance.
REQ-023 The block SHALL issue exactly one event per handshake and SHALL NOT drop or duplicate events.
REQ-024 event_valid SHALL never be asserted outside EMIT.
REQ-025 event_ready SHALL be ignored while event_valid = 0.
REQ-026 Each cnt[k] SHALL be $clog2(DEBOUNCE_SCANS) bits wide, SHALL never exceed DEBOUNCE_SCANS-1, and SHALL NOT wrap.
REQ-027 With no events, a column period SHALL be SETTLE_CYCLES + 4 cycles and a full scan SHALL be 4 x (SETTLE_CYCLES + 4) cycles.
REQ-028 A key's debounced state SHALL change only after DEBOUNCE_SCANS consecutive scans of that key disagree with keys_state; any agreeing scan restarts the count.
REQ-029 The block SHALL NOT implement ghost or anti-ghosting logic; multiple simultaneous keys are each debounced independently.
REQ-030 If several keys in one column qualify in the same scan, the block SHALL emit them in ascending row order, each through its own EMIT.

Reset
REQ-031 While reset = 1 at a clock edge, the next state SHALL be:
- col_out = 4'b1110, col = 0, row = 0;
- state SETTLE with counter = SETTLE_CYCLES-1;
- event_valid = 0, event_key = 0, event_pressed = 0;
- keys_state = 0 and all cnt = 0.
REQ-032 Reset SHALL take priority in every state, including mid-EMIT; a pending event is discarded.
REQ-033 The synchronizer flops SHALL NOT require reset.

Verification
REQ-034 Reset test: hold reset 2 cycles with row_in = 4'hF, then release and run 10 scans. Required: col_out cycles 1110, 1101, 1011, 0111 with SETTLE_CYCLES + 4 cycles per column, event_valid stays 0 and keys_state = 0.
REQ-035 Press test: row_in[1] = 0 only while col_out[1] = 0, with event_ready = 1. Required: one event with event_key = 5 and event_pressed = 1 on the 4th scan; keys_state = 16'h0020 thereafter.
REQ-036 Bounce test: key 5 appears pressed for 3 consecutive scans, then released for 1 scan, repeated 5 times. Required: no event and keys_state stays 0.
REQ-037 Backpressure test: keys 0 and 4 (same column) pressed, event_ready = 0 for 50 cycles, then 1. Required:
- event_valid, event_key = 0 and col_out stay frozen while event_ready = 0;
- after release, events key 0 then key 4, each accepted once.
REQ-038 Release test: after REQ-035, set row_in = 4'hF. Required: after 4 scans one event with event_key = 5, event_pressed = 0, and keys_state returns to 0.
REQ-039 Reset-mid-EMIT test: assert reset 1 cycle while event_valid = 1 and event_ready = 0. Required: next cycle event_valid = 0, keys_state = 0 and col_out = 4'b1110.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix one column at a time.
// Each sampled key is debounced individually, and every debounced press or
// release is presented as an event on a valid/ready handshake.
//
// Ports:
//   clk           - clock; all logic runs on the rising edge
//   reset         - synchronous, active-high reset
//   col_out[3:0]  - active-low column drive; exactly one bit is low
//   row_in[3:0]   - asynchronous, active-low row sense (0 = pressed)
//   event_valid   - a key event is pending
//   event_ready   - the consumer accepts the pending event
//   event_key     - key index of the event, row*4 + col
//   event_pressed - 1 = press, 0 = release
//   keys_state    - debounced pressed map; bit k is key k
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  col_out,
    input  logic [3:0]  row_in,
    output logic        event_valid,
    input  logic        event_ready,
    output logic [3:0]  event_key,
    output logic        event_pressed,
    output logic [15:0] keys_state
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS);
    localparam int unsigned SetW = $clog2(SETTLE_CYCLES);
    localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_SCANS - 1);
    localparam logic [SetW-1:0] SetLoad = SetW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StSettle, StCheck, StEmit} state_e;

    state_e            state_q, state_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        col_out_q, col_out_d;
    logic [3:0]        sample_q, sample_d;
    logic [15:0]       keys_q, keys_d;
    logic [CntW-1:0]   cnt_q [16];
    logic [CntW-1:0]   cnt_d [16];
    logic              ev_valid_q, ev_valid_d;
    logic [3:0]        ev_key_q, ev_key_d;
    logic              ev_pressed_q, ev_pressed_d;

    logic [3:0]        row_meta_q, row_sync_q;

    logic [3:0]        key_idx;
    logic              cur_sample;
    logic              cur_state;
    logic              do_adv;

    // Two-flop synchronizer; no reset needed since its contents are flushed
    // long before the first sample is taken.
    always_ff @(posedge clk) begin
        row_meta_q <= row_in;
        row_sync_q <= row_meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StSettle;
            settle_q     <= SetLoad;
            col_q        <= 2'd0;
            row_q        <= 2'd0;
            col_out_q    <= 4'b1110;
            sample_q     <= 4'd0;
            keys_q       <= 16'd0;
            ev_valid_q   <= 1'b0;
            ev_key_q     <= 4'd0;
            ev_pressed_q <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            col_q        <= col_d;
            row_q        <= row_d;
            col_out_q    <= col_out_d;
            sample_q     <= sample_d;
            keys_q       <= keys_d;
            ev_valid_q   <= ev_valid_d;
            ev_key_q     <= ev_key_d;
            ev_pressed_q <= ev_pressed_d;
            for (int k = 0; k < 16; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        col_d        = col_q;
        row_d        = row_q;
        col_out_d    = col_out_q;
        sample_d     = sample_q;
        keys_d       = keys_q;
        ev_valid_d   = ev_valid_q;
        ev_key_d     = ev_key_q;
        ev_pressed_d = ev_pressed_q;
        for (int k = 0; k < 16; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        do_adv     = 1'b0;
        key_idx    = {row_q, col_q};
        cur_sample = sample_q[row_q];
        cur_state  = keys_q[key_idx];

        case (state_q)
            StSettle: begin
                if (settle_q == '0) begin
                    sample_d = ~row_sync_q;
                    row_d    = 2'd0;
                    state_d  = StCheck;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            StCheck: begin
                if (cur_sample == cur_state) begin
                    cnt_d[key_idx] = '0;
                    do_adv         = 1'b1;
                end else if (cnt_q[key_idx] < CntMax) begin
                    cnt_d[key_idx] = cnt_q[key_idx] + 1'b1;
                    do_adv         = 1'b1;
                end else begin
                    cnt_d[key_idx]  = '0;
                    keys_d[key_idx] = ~cur_state;
                    ev_key_d        = key_idx;
                    ev_pressed_d    = cur_sample;
                    ev_valid_d      = 1'b1;
                    state_d         = StEmit;
                end
            end
            StEmit: begin
                // Everything holds until the consumer takes the event.
                if (event_ready) begin
                    ev_valid_d = 1'b0;
                    do_adv     = 1'b1;
                end
            end
            default: begin
                state_d  = StSettle;
                settle_d = SetLoad;
            end
        endcase

        if (do_adv) begin
            if (row_q != 2'd3) begin
                row_d   = row_q + 2'd1;
                state_d = StCheck;
            end else begin
                col_d     = col_q + 2'd1;
                col_out_d = ~(4'b0001 << col_d);
                settle_d  = SetLoad;
                state_d   = StSettle;
            end
        end
    end

    assign col_out       = col_out_q;
    assign event_valid   = ev_valid_q;
    assign event_key     = ev_key_q;
    assign event_pressed = ev_pressed_q;
    assign keys_state    = keys_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner. A behavioural key matrix drives row_in from
// col_out; expected events go into a queue and are popped at each handshake.
module tb_keypad_scanner;

    localparam int S    = 5;
    localparam int D    = 4;
    localparam int P    = S + 4;
    localparam int SCAN = 4 * P;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col_out;
    logic [3:0]  row_in;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic [3:0]  event_key;
    logic        event_pressed;
    logic [15:0] keys_state;

    logic [15:0] tb_keys = 16'd0;

    typedef struct packed {
        logic [3:0] key;
        logic       pressed;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    int checks = 0;
    int errors = 0;

    keypad_scanner #(
        .SETTLE_CYCLES (S),
        .DEBOUNCE_SCANS(D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .col_out      (col_out),
        .row_in       (row_in),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_key    (event_key),
        .event_pressed(event_pressed),
        .keys_state   (keys_state)
    );

    always #5 clk = ~clk;

    // Key matrix: a held key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_out[c] && tb_keys[r*4+c]) row_in[r] = 1'b0;
            end
        end
    end

    // Scoreboard: every accepted event must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got key %0d pressed %0b, required no event",
                         event_key, event_pressed);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (event_key !== mon_e.key || event_pressed !== mon_e.pressed) begin
                    errors++;
                    $display("FAIL event_match: got key %0d pressed %0b, required key %0d pressed %0b",
                             event_key, event_pressed, mon_e.key, mon_e.pressed);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        exp_q.delete();
        tb_keys = 16'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] ec;
        event_ready = 1'b0;
        do_reset();
        checks++;
        if (col_out !== 4'b1110 || event_valid !== 1'b0 || event_key !== 4'd0 ||
            event_pressed !== 1'b0 || keys_state !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got col %b valid %b key %0d pr %b keys %h, required 1110 0 0 0 0000",
                     col_out, event_valid, event_key, event_pressed, keys_state);
        end
        for (int i = 0; i < 10 * SCAN; i++) begin
            ec = ~(4'b0001 << ((i / P) % 4));
            checks++;
            if (col_out !== ec || event_valid !== 1'b0 || keys_state !== 16'd0) begin
                errors++;
                $display("FAIL idle_scan cycle %0d: got col %b valid %b keys %h, required col %b valid 0 keys 0000",
                         i, col_out, event_valid, keys_state, ec);
            end
            step();
        end
    endtask

    task automatic test_press;
        int n = 0;
        event_ready = 1'b1;
        do_reset();
        tb_keys = 16'h0020;
        exp_q.push_back('{key: 4'd5, pressed: 1'b1});
        while (!event_valid && n < 6 * SCAN) begin
            step();
            n++;
        end
        checks++;
        if (n !== 3 * SCAN + P + S + 2) begin
            errors++;
            $display("FAIL press_latency: got %0d cycles, required %0d", n, 3 * SCAN + P + S + 2);
        end
        step();
        checks++;
        if (event_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL press_accept: got valid %b pending %0d, required valid 0 pending 0",
                     event_valid, exp_q.size());
        end
        repeat (SCAN) step();
        checks++;
        if (keys_state !== 16'h0020) begin
            errors++;
            $display("FAIL press_keys: got %h, required 0020", keys_state);
        end
    endtask

    // Continues straight from test_press with key 5 held in the debounced map.
    task automatic test_release;
        int n = 0;
        tb_keys = 16'd0;
        exp_q.push_back('{key: 4'd5, pressed: 1'b0});
        while (!event_valid && n < 6 * SCAN) begin
            step();
            n++;
        end
        checks++;
        if (n !== 4 * SCAN) begin
            errors++;
            $display("FAIL release_latency: got %0d cycles, required %0d", n, 4 * SCAN);
        end
        step();
        checks++;
        if (keys_state !== 16'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL release_keys: got keys %h pending %0d, required 0000 pending 0",
                     keys_state, exp_q.size());
        end
    endtask

    task automatic test_bounce;
        event_ready = 1'b1;
        do_reset();
        for (int it = 0; it < 5; it++) begin
            tb_keys = 16'h0020;
            repeat (3 * SCAN) step();
            tb_keys = 16'd0;
            repeat (SCAN) step();
            checks++;
            if (keys_state !== 16'd0 || event_valid !== 1'b0) begin
                errors++;
                $display("FAIL bounce iter %0d: got keys %h valid %b, required 0000 0",
                         it, keys_state, event_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        int n = 0;
        logic [3:0] cap;
        event_ready = 1'b0;
        do_reset();
        tb_keys = 16'h0011;
        exp_q.push_back('{key: 4'd0, pressed: 1'b1});
        exp_q.push_back('{key: 4'd4, pressed: 1'b1});
        while (!event_valid && n < 6 * SCAN) begin
            step();
            n++;
        end
        checks++;
        if (n !== 3 * SCAN + S + 1) begin
            errors++;
            $display("FAIL bp_latency: got %0d cycles, required %0d", n, 3 * SCAN + S + 1);
        end
        cap = col_out;
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (event_valid !== 1'b1 || event_key !== 4'd0 || event_pressed !== 1'b1 ||
                col_out !== cap || keys_state !== 16'h0001) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid %b key %0d pr %b col %b keys %h, required 1 0 1 %b 0001",
                         i, event_valid, event_key, event_pressed, col_out, keys_state, cap);
            end
            step();
        end
        event_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        step();
        checks++;
        if (exp_q.size() != 0 || event_valid !== 1'b0 || keys_state !== 16'h0011) begin
            errors++;
            $display("FAIL bp_drain: got pending %0d valid %b keys %h, required 0 0 0011",
                     exp_q.size(), event_valid, keys_state);
        end
    endtask

    task automatic test_reset_mid_emit;
        int n = 0;
        event_ready = 1'b0;
        do_reset();
        tb_keys = 16'h0020;
        while (!event_valid && n < 6 * SCAN) begin
            step();
            n++;
        end
        checks++;
        if (event_valid !== 1'b1 || event_key !== 4'd5) begin
            errors++;
            $display("FAIL rme_pending: got valid %b key %0d, required 1 5", event_valid, event_key);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tb_keys = 16'd0;
        checks++;
        if (event_valid !== 1'b0 || keys_state !== 16'd0 || col_out !== 4'b1110 ||
            event_key !== 4'd0 || event_pressed !== 1'b0) begin
            errors++;
            $display("FAIL rme_state: got valid %b keys %h col %b key %0d pr %b, required 0 0000 1110 0 0",
                     event_valid, keys_state, col_out, event_key, event_pressed);
        end
        event_ready = 1'b1;
        repeat (SCAN) step();
        checks++;
        if (event_valid !== 1'b0 || keys_state !== 16'd0) begin
            errors++;
            $display("FAIL rme_after: got valid %b keys %h, required 0 0000", event_valid, keys_state);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_backpressure();
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
